video_timing_v: RTL and testbench

VIDEO_TIMING_V -- requirements
Module: video_timing_v

---
 rtl/video_timing_v.sv | 171 +++++++++++++++++
 tb/tb_video_timing_v.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_v.sv
`default_nettype none
// ============================================================================
// video_timing_v : raster timing generator with pixel/line doubling support.
// Optional bar test picture when VIDEO_TIMING_TEST_PICTURE_EN is defined.
// Revision: 1.0
// ============================================================================
module video_timing_v #(
   parameter int RES_X     = 640,
   parameter int H_FP      = 16,
   parameter int H_PULSE   = 96,
   parameter int H_BP      = 48,
   parameter int RES_Y     = 480,
   parameter int V_FP      = 10,
   parameter int V_PULSE   = 2,
   parameter int V_BP      = 33,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int DBL_X     = 0,
   parameter int DBL_Y     = 0
) (
   input  logic        clk_pixel,
   input  logic        rst_n,
   input  logic        test_mode,
   input  logic [7:0]  red_byte,
   input  logic [7:0]  green_byte,
   input  logic [7:0]  blue_byte,
   output logic        fetch_next,
   output logic        line_repeat,
   output logic        frame_start,
   output logic        vga_de,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic [11:0] pos_x,
   output logic [11:0] pos_y
);

   localparam int FRAME_X = RES_X + H_FP + H_PULSE + H_BP;
   localparam int FRAME_Y = RES_Y + V_FP + V_PULSE + V_BP;

   // 13-bit bounds so a sync window ending exactly at 4096 still compares correctly
   localparam logic [12:0] C_X_LAST   = 13'(FRAME_X - 1);
   localparam logic [12:0] C_Y_LAST   = 13'(FRAME_Y - 1);
   localparam logic [12:0] C_RES_X    = 13'(RES_X);
   localparam logic [12:0] C_RES_Y    = 13'(RES_Y);
   localparam logic [12:0] C_HS_START = 13'(RES_X + H_FP);
   localparam logic [12:0] C_HS_END   = 13'(RES_X + H_FP + H_PULSE);
   localparam logic [12:0] C_VS_START = 13'(RES_Y + V_FP);
   localparam logic [12:0] C_VS_END   = 13'(RES_Y + V_FP + V_PULSE);
   localparam logic        C_HPOL     = (HSYNC_POL != 0);
   localparam logic        C_VPOL     = (VSYNC_POL != 0);
   localparam logic        C_DBL_X    = (DBL_X != 0);
   localparam logic        C_DBL_Y    = (DBL_Y != 0);

   logic [11:0] cx_q, cx_d, cy_q, cy_d;
   logic [12:0] cx_w, cy_w;
   logic        active, active_y, pix_load;
   logic [7:0]  src_r, src_g, src_b;

   logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic        fs_q, fs_d, lr_q, lr_d;
   logic        hs_raw, vs_raw;
   logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic [11:0] px_q, px_d, py_q, py_d;

   assign cx_w     = {1'b0, cx_q};
   assign cy_w     = {1'b0, cy_q};
   assign active_y = (cy_w < C_RES_Y);
   assign active   = (cx_w < C_RES_X) && active_y;
   assign pix_load = !C_DBL_X || !cx_q[0];

   // With doubling, the word is captured on the even pixel and released on the odd one
   assign fetch_next = active && (!C_DBL_X || cx_q[0]);

`ifdef VIDEO_TIMING_TEST_PICTURE_EN
   always_comb begin
      src_r = red_byte;
      src_g = green_byte;
      src_b = blue_byte;
      if (test_mode) begin
         src_r = {8{cx_q[7]}};
         src_g = {8{cx_q[6]}};
         src_b = {8{cx_q[5]}};
      end
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign src_r = red_byte;
   assign src_g = green_byte;
   assign src_b = blue_byte;
`endif

   always_comb begin
      cx_d = cx_q + 12'd1;
      cy_d = cy_q;
      if (cx_w == C_X_LAST) begin
         cx_d = '0;
         cy_d = (cy_w == C_Y_LAST) ? '0 : cy_q + 12'd1;
      end

      hs_raw = (cx_w >= C_HS_START) && (cx_w < C_HS_END);
      vs_raw = (cy_w >= C_VS_START) && (cy_w < C_VS_END);
      hs_d   = C_HPOL ? hs_raw : ~hs_raw;
      vs_d   = C_VPOL ? vs_raw : ~vs_raw;

      de_d = active;
      fs_d = (cx_q == '0) && (cy_q == '0);
      lr_d = C_DBL_Y && (cx_w == C_HS_START) && active_y && !cy_q[0];
      px_d = cx_q;
      py_d = cy_q;

      r_d = r_q;
      g_d = g_q;
      b_d = b_q;
      if (!active) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end else if (pix_load) begin
         r_d = src_r;
         g_d = src_g;
         b_d = src_b;
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         cx_q <= '0;
         cy_q <= '0;
         de_q <= 1'b0;
         hs_q <= ~C_HPOL;
         vs_q <= ~C_VPOL;
         fs_q <= 1'b0;
         lr_q <= 1'b0;
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
         px_q <= '0;
         py_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
         de_q <= de_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         fs_q <= fs_d;
         lr_q <= lr_d;
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
         px_q <= px_d;
         py_q <= py_d;
      end
   end

   assign vga_de      = de_q;
   assign vga_hsync   = hs_q;
   assign vga_vsync   = vs_q;
   assign frame_start = fs_q;
   assign line_repeat = lr_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign pos_x       = px_q;
   assign pos_y       = py_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_v.sv
`default_nettype none
// ============================================================================
// tb_video_timing_v : randomized bench for video_timing_v against an
// arithmetic frame model, two configurations (plain, doubled/odd/positive sync).
// Revision: 1.0
// ============================================================================
module tb_video_timing_v;

   typedef struct packed {
      int rx; int hfp; int hp; int hbp;
      int ry; int vfp; int vp; int vbp;
      int hpol; int vpol; int dx; int dy;
   } cfg_t;

   localparam cfg_t CFG0 = '{rx:80, hfp:4, hp:8, hbp:4, ry:6, vfp:1, vp:2, vbp:1,
                             hpol:0, vpol:0, dx:0, dy:0};
   localparam cfg_t CFG1 = '{rx:21, hfp:2, hp:4, hbp:3, ry:9, vfp:1, vp:3, vbp:2,
                             hpol:1, vpol:1, dx:1, dy:1};

   logic       clk_pixel;
   logic       rst_n;
   logic       test_mode;
   logic [7:0] red_byte, green_byte, blue_byte;

   logic        fn0, lr0, fs0, de0, hs0, vs0;
   logic [7:0]  r0, g0, b0;
   logic [11:0] px0, py0;
   logic        fn1, lr1, fs1, de1, hs1, vs1;
   logic [7:0]  r1, g1, b1;
   logic [11:0] px1, py1;

   int n_checks;
   int n_err;
   int t;

   logic [7:0] h_r [4];
   logic [7:0] h_g [4];
   logic [7:0] h_b [4];
   logic       h_tm[4];

   video_timing_v #(
      .RES_X(CFG0.rx), .H_FP(CFG0.hfp), .H_PULSE(CFG0.hp), .H_BP(CFG0.hbp),
      .RES_Y(CFG0.ry), .V_FP(CFG0.vfp), .V_PULSE(CFG0.vp), .V_BP(CFG0.vbp),
      .HSYNC_POL(CFG0.hpol), .VSYNC_POL(CFG0.vpol), .DBL_X(CFG0.dx), .DBL_Y(CFG0.dy)
   ) u_dut0 (
      .clk_pixel(clk_pixel), .rst_n(rst_n), .test_mode(test_mode),
      .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
      .fetch_next(fn0), .line_repeat(lr0), .frame_start(fs0), .vga_de(de0),
      .vga_hsync(hs0), .vga_vsync(vs0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
      .pos_x(px0), .pos_y(py0)
   );

   video_timing_v #(
      .RES_X(CFG1.rx), .H_FP(CFG1.hfp), .H_PULSE(CFG1.hp), .H_BP(CFG1.hbp),
      .RES_Y(CFG1.ry), .V_FP(CFG1.vfp), .V_PULSE(CFG1.vp), .V_BP(CFG1.vbp),
      .HSYNC_POL(CFG1.hpol), .VSYNC_POL(CFG1.vpol), .DBL_X(CFG1.dx), .DBL_Y(CFG1.dy)
   ) u_dut1 (
      .clk_pixel(clk_pixel), .rst_n(rst_n), .test_mode(test_mode),
      .red_byte(red_byte), .green_byte(green_byte), .blue_byte(blue_byte),
      .fetch_next(fn1), .line_repeat(lr1), .frame_start(fs1), .vga_de(de1),
      .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
      .pos_x(px1), .pos_y(py1)
   );

   initial clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   // Pixel value shown for frame step s: doubled pixels reuse the word captured one step earlier.
   function automatic logic [23:0] exp_rgb(input cfg_t c, input int s);
      int fx, fy, cx, cy, src, scx;
      fx  = c.rx + c.hfp + c.hp + c.hbp;
      fy  = c.ry + c.vfp + c.vp + c.vbp;
      cx  = s % fx;
      cy  = (s / fx) % fy;
      if (!(cx < c.rx && cy < c.ry)) return 24'h0;
      src = (c.dx != 0 && cx % 2 == 1) ? s - 1 : s;
      scx = src % fx;
`ifdef VIDEO_TIMING_TEST_PICTURE_EN
      if (h_tm[src % 4]) return {{8{scx[7]}}, {8{scx[6]}}, {8{scx[5]}}};
`endif
      if (scx < 0) return 24'h0;
      return {h_r[src % 4], h_g[src % 4], h_b[src % 4]};
   endfunction

   task automatic check_inst(input string p, input cfg_t c,
                             input logic fn, input logic lr, input logic fs, input logic de,
                             input logic hs, input logic vs,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [11:0] px, input logic [11:0] py);
      int   fx, fy, s, cx, cy, ncx, ncy;
      logic hin, vin;
      fx  = c.rx + c.hfp + c.hp + c.hbp;
      fy  = c.ry + c.vfp + c.vp + c.vbp;
      ncx = t % fx;
      ncy = (t / fx) % fy;
      check_eq({p, "fetch_next"}, 32'(fn),
               32'(ncx < c.rx && ncy < c.ry && (c.dx == 0 || ncx % 2 == 1)));
      s   = t - 1;
      cx  = s % fx;
      cy  = (s / fx) % fy;
      hin = (cx >= c.rx + c.hfp) && (cx < c.rx + c.hfp + c.hp);
      vin = (cy >= c.ry + c.vfp) && (cy < c.ry + c.vfp + c.vp);
      check_eq({p, "vga_de"}, 32'(de), 32'(cx < c.rx && cy < c.ry));
      check_eq({p, "hsync"}, 32'(hs), 32'((c.hpol != 0) ? hin : !hin));
      check_eq({p, "vsync"}, 32'(vs), 32'((c.vpol != 0) ? vin : !vin));
      check_eq({p, "frame_start"}, 32'(fs), 32'(cx == 0 && cy == 0));
      check_eq({p, "line_repeat"}, 32'(lr),
               32'(c.dy != 0 && cx == c.rx + c.hfp && cy < c.ry && cy % 2 == 0));
      check_eq({p, "rgb"}, 32'({r, g, b}), 32'(exp_rgb(c, s)));
      check_eq({p, "pos_x"}, 32'(px), 32'(cx));
      check_eq({p, "pos_y"}, 32'(py), 32'(cy));
   endtask

   task automatic check_rst(input string p, input cfg_t c,
                            input logic fn, input logic lr, input logic fs, input logic de,
                            input logic hs, input logic vs,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [11:0] px, input logic [11:0] py);
      check_eq({p, "rst_fetch_next"}, 32'(fn), 32'(c.dx == 0));
      check_eq({p, "rst_vga_de"}, 32'(de), 32'd0);
      check_eq({p, "rst_frame_start"}, 32'(fs), 32'd0);
      check_eq({p, "rst_line_repeat"}, 32'(lr), 32'd0);
      check_eq({p, "rst_hsync"}, 32'(hs), 32'(c.hpol == 0));
      check_eq({p, "rst_vsync"}, 32'(vs), 32'(c.vpol == 0));
      check_eq({p, "rst_rgb"}, 32'({r, g, b}), 32'd0);
      check_eq({p, "rst_pos"}, 32'({px, py}), 32'd0);
   endtask

   task automatic check_all_rst();
      check_rst("dut0.", CFG0, fn0, lr0, fs0, de0, hs0, vs0, r0, g0, b0, px0, py0);
      check_rst("dut1.", CFG1, fn1, lr1, fs1, de1, hs1, vs1, r1, g1, b1, px1, py1);
   endtask

   task automatic drive();
      red_byte   = 8'($urandom);
      green_byte = 8'($urandom);
      blue_byte  = 8'($urandom);
      test_mode  = ($urandom_range(0, 3) == 0);
      h_r[t % 4]  = red_byte;
      h_g[t % 4]  = green_byte;
      h_b[t % 4]  = blue_byte;
      h_tm[t % 4] = test_mode;
   endtask

   // Called at a negedge: releases reset, then steps n cycles checking after each edge.
   task automatic release_and_run(input int n);
      t     = 0;
      rst_n = 1'b1;
      for (int k = 0; k < n; k++) begin
         drive();
         @(negedge clk_pixel);
         t++;
         check_inst("dut0.", CFG0, fn0, lr0, fs0, de0, hs0, vs0, r0, g0, b0, px0, py0);
         check_inst("dut1.", CFG1, fn1, lr1, fs1, de1, hs1, vs1, r1, g1, b1, px1, py1);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_err      = 0;
      t          = 0;
      rst_n      = 1'b0;
      test_mode  = 1'b0;
      red_byte   = '0;
      green_byte = '0;
      blue_byte  = '0;
      for (int i = 0; i < 4; i++) begin
         h_r[i] = '0; h_g[i] = '0; h_b[i] = '0; h_tm[i] = 1'b0;
      end

      repeat (3) @(negedge clk_pixel);
      check_all_rst();
      release_and_run(2000 + int'($urandom_range(0, 400)));

      // Abandon the frame mid-way and hold reset for three cycles
      rst_n = 1'b0;
      #1;
      check_all_rst();
      repeat (3) begin
         @(negedge clk_pixel);
         check_all_rst();
      end
      release_and_run(1200 + int'($urandom_range(0, 400)));

      rst_n = 1'b0;
      repeat (2) @(negedge clk_pixel);
      check_all_rst();
      release_and_run(600);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
